// File: rtl/rate_sel.sv
// rate_sel: operator-side playback-rate selector.
//   Turns debounced push-button levels into a saturating rate code (1..8)
//   with hold-to-repeat, keeps the fast/slow mode flag, and on every audio
//   sample tick emits the playback address step (fast = skip o_rate samples,
//   slow = advance by one every o_rate ticks).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_key_up        raise-rate key level
//   i_key_down      lower-rate key level
//   i_mode_toggle   fast/slow toggle key level
//   i_lock          1 = ignore all keys
//   i_sample_tick   one-cycle pulse per audio sample
//   o_rate          rate code 1..8
//   o_fast          1 = fast (skip), 0 = slow (hold)
//   o_rate_chg      one-cycle pulse after o_rate/o_fast changed
//   o_step_en       advance playback address this sample
//   o_step_inc      address increment, valid with o_step_en
module rate_sel #(
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000,
  parameter int CNT_W      = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_key_up,
  input  logic       i_key_down,
  input  logic       i_mode_toggle,
  input  logic       i_lock,
  input  logic       i_sample_tick,
  output logic [3:0] o_rate,
  output logic       o_fast,
  output logic       o_rate_chg,
  output logic       o_step_en,
  output logic [3:0] o_step_inc
);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_up_q, r_dn_q, r_tg_q;
  logic             r_arm;
  logic             r_dir, w_dir_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_rate, w_rate_nxt, w_rate_m1;
  logic             r_fast, w_fast_nxt;
  logic             r_rate_chg;
  logic [3:0]       r_div, w_div_base;
  logic             r_step_en;
  logic [3:0]       r_step_inc;

  logic w_live, w_press_up, w_press_dn, w_press_tg;
  logic w_held, w_exit, w_step, w_cnt_clr;
  logic w_up_ev, w_dn_ev, w_chg;

  // r_arm stays low for the first cycle after reset so a key that was held
  // through reset is absorbed into the history registers, not seen as a press.
  assign w_live     = r_arm & ~i_lock;
  assign w_press_up = w_live & i_key_up      & ~r_up_q;
  assign w_press_dn = w_live & i_key_down    & ~r_dn_q;
  assign w_press_tg = w_live & i_mode_toggle & ~r_tg_q;

  assign w_held = r_dir ? i_key_up : i_key_down;
  assign w_exit = i_lock | ~w_held | (i_key_up & i_key_down);

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_step      = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((w_press_up | w_press_dn) & (i_key_up ^ i_key_down)) begin
          w_state_nxt = S_DELAY;
          w_dir_nxt   = i_key_up;
          w_cnt_clr   = 1'b1;
        end
      end
      S_DELAY: begin
        if (w_exit) begin
          w_state_nxt = S_IDLE;
          w_cnt_clr   = 1'b1;
        end else if (r_cnt == DLY_LAST) begin
          w_state_nxt = S_REPEAT;
          w_step      = 1'b1;
          w_cnt_clr   = 1'b1;
        end
      end
      S_REPEAT: begin
        if (w_exit) begin
          w_state_nxt = S_IDLE;
          w_cnt_clr   = 1'b1;
        end else if (r_cnt == PER_LAST) begin
          w_step    = 1'b1;
          w_cnt_clr = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_up_q  <= 1'b0;
      r_dn_q  <= 1'b0;
      r_tg_q  <= 1'b0;
      r_arm   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= (w_cnt_clr || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
      r_up_q  <= i_key_up;
      r_dn_q  <= i_key_down;
      r_tg_q  <= i_mode_toggle;
      r_arm   <= 1'b1;
    end
  end

  // Opposing events in one cycle cancel; steps at the limits are no-ops.
  assign w_up_ev = w_press_up | (w_step &  r_dir);
  assign w_dn_ev = w_press_dn | (w_step & ~r_dir);

  always_comb begin
    w_rate_nxt = r_rate;
    if (w_up_ev && !w_dn_ev && r_rate != 4'd8)
      w_rate_nxt = r_rate + 4'd1;
    else if (w_dn_ev && !w_up_ev && r_rate != 4'd1)
      w_rate_nxt = r_rate - 4'd1;
  end

  assign w_fast_nxt = r_fast ^ w_press_tg;
  assign w_chg      = (w_rate_nxt != r_rate) | (w_fast_nxt != r_fast);
  assign w_rate_m1  = w_rate_nxt - 4'd1;
  // A tick coinciding with a change counts as tick 0 of the new rate.
  assign w_div_base = w_chg ? 4'd0 : r_div;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rate     <= 4'd1;
      r_fast     <= 1'b1;
      r_rate_chg <= 1'b0;
      r_div      <= 4'd0;
      r_step_en  <= 1'b0;
      r_step_inc <= 4'd0;
    end else begin
      r_rate     <= w_rate_nxt;
      r_fast     <= w_fast_nxt;
      r_rate_chg <= w_chg;
      r_step_en  <= 1'b0;
      r_div      <= w_div_base;
      if (i_sample_tick) begin
        if (w_fast_nxt) begin
          r_step_en  <= 1'b1;
          r_step_inc <= w_rate_nxt;
          r_div      <= 4'd0;
        end else begin
          r_step_inc <= 4'd1;
          if (w_div_base == w_rate_m1) begin
            r_step_en <= 1'b1;
            r_div     <= 4'd0;
          end else begin
            r_div <= w_div_base + 4'd1;
          end
        end
      end
    end
  end

  assign o_rate     = r_rate;
  assign o_fast     = r_fast;
  assign o_rate_chg = r_rate_chg;
  assign o_step_en  = r_step_en;
  assign o_step_inc = r_step_inc;

endmodule

// File: tb/tb_rate_sel.sv
module tb_rate_sel;

  logic       clk;
  logic       rst;
  logic       i_key_up, i_key_down, i_mode_toggle, i_lock, i_sample_tick;
  logic [3:0] o_rate;
  logic       o_fast, o_rate_chg, o_step_en;
  logic [3:0] o_step_inc;

  rate_sel #(.REPEAT_DLY(8), .REPEAT_PER(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_key_up(i_key_up), .i_key_down(i_key_down),
    .i_mode_toggle(i_mode_toggle), .i_lock(i_lock),
    .i_sample_tick(i_sample_tick),
    .o_rate(o_rate), .o_fast(o_fast), .o_rate_chg(o_rate_chg),
    .o_step_en(o_step_en), .o_step_inc(o_step_inc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       up, dn, tg, lock;
    bit [3:0] rate;
    bit       fast, chg;
  } vec_t;

  typedef struct {
    int cyc;
    int inc;
  } step_t;

  vec_t  tbl[22];
  step_t sb_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc_n = 0;
  int    chg_cnt = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, and retire any
  // step output against the scoreboard.
  task automatic cyc();
    step_t e;
    @(posedge clk);
    #1;
    cyc_n++;
    if (o_rate_chg) chg_cnt++;
    if (o_step_en) begin
      if (sb_q.size() == 0) begin
        chk("step_unexpected_cycle", cyc_n, -1);
      end else begin
        e = sb_q.pop_front();
        chk("step_cycle", cyc_n, e.cyc);
        chk("step_inc", int'(o_step_inc), e.inc);
      end
    end
  endtask

  // Drive a sample tick for the coming edge; push a step if one is expected.
  task automatic tick(input bit expect_step, input int inc);
    i_sample_tick = 1'b1;
    if (expect_step) sb_q.push_back('{cyc_n + 1, inc});
    cyc();
    i_sample_tick = 1'b0;
    cyc();
  endtask

  task automatic press_up();
    i_key_up = 1'b1;
    cyc();
    i_key_up = 1'b0;
    cyc();
  endtask

  initial begin
    int chg0, exp_rate, prev;
    bit stp;

    // up, dn, tg, lock, rate, fast, chg (values after the press edge)
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1};
    tbl[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0};

    rst = 1'b1;
    i_key_up = 1'b0; i_key_down = 1'b0; i_mode_toggle = 1'b0;
    i_lock = 1'b0; i_sample_tick = 1'b0;
    cyc();
    cyc();
    chk("reset_rate", int'(o_rate), 1);
    chk("reset_fast", int'(o_fast), 1);
    chk("reset_chg", int'(o_rate_chg), 0);
    chk("reset_step_en", int'(o_step_en), 0);
    chk("reset_step_inc", int'(o_step_inc), 0);
    rst = 1'b0;
    cyc();

    // Key press vectors: one cycle pressed, three released.
    chg0 = chg_cnt;
    for (int i = 0; i < 22; i++) begin
      i_key_up = tbl[i].up; i_key_down = tbl[i].dn;
      i_mode_toggle = tbl[i].tg; i_lock = tbl[i].lock;
      cyc();
      chk($sformatf("vec%0d_rate", i), int'(o_rate), int'(tbl[i].rate));
      chk($sformatf("vec%0d_fast", i), int'(o_fast), int'(tbl[i].fast));
      chk($sformatf("vec%0d_chg", i), int'(o_rate_chg), int'(tbl[i].chg));
      i_key_up = 1'b0; i_key_down = 1'b0; i_mode_toggle = 1'b0; i_lock = 1'b0;
      for (int j = 0; j < 3; j++) begin
        cyc();
        chk($sformatf("vec%0d_rel%0d_chg", i, j), int'(o_rate_chg), 0);
        chk($sformatf("vec%0d_rel%0d_rate", i, j), int'(o_rate), int'(tbl[i].rate));
      end
      if (i == 9) chk("ten_up_chg_pulses", chg_cnt - chg0, 7);
    end

    // Down to rate 3 for the step tests.
    i_key_down = 1'b1;
    cyc();
    i_key_down = 1'b0;
    cyc();
    chk("pre_step_rate", int'(o_rate), 3);

    // Fast mode: every tick steps by o_rate.
    for (int t = 0; t < 5; t++) tick(1'b1, 3);
    cyc();
    chk("fast_sb_empty", sb_q.size(), 0);

    // Slow mode at rate 3: steps on ticks 3, 6, 9.
    chg0 = chg_cnt;
    i_mode_toggle = 1'b1;
    cyc();
    i_mode_toggle = 1'b0;
    chk("slow_fast_flag", int'(o_fast), 0);
    cyc();
    for (int t = 1; t <= 9; t++) tick(t % 3 == 0, 1);
    cyc();
    chk("slow_sb_empty", sb_q.size(), 0);
    chk("slow_toggle_chg_pulses", chg_cnt - chg0, 1);

    // Tick together with a rate change: counts as tick 0 at rate 4.
    i_key_up = 1'b1;
    i_sample_tick = 1'b1;
    cyc();
    i_key_up = 1'b0;
    i_sample_tick = 1'b0;
    chk("tick_chg_rate", int'(o_rate), 4);
    cyc();
    tick(1'b0, 1);
    tick(1'b0, 1);
    tick(1'b1, 1);
    cyc();
    chk("tick_chg_sb_empty", sb_q.size(), 0);

    // Lock released with up still held: no press, no repeat.
    chg0 = chg_cnt;
    i_lock = 1'b1;
    cyc();
    i_key_up = 1'b1;
    repeat (3) cyc();
    i_lock = 1'b0;
    repeat (12) cyc();
    chk("lock_hold_rate", int'(o_rate), 4);
    chk("lock_hold_chg", chg_cnt - chg0, 0);
    i_key_up = 1'b0;
    cyc();

    // Up to 8, then hold down: press step, +8, then every 4, saturating at 1.
    repeat (4) press_up();
    chk("pre_repeat_rate", int'(o_rate), 8);
    exp_rate = 8;
    i_key_down = 1'b1;
    for (int k = 0; k < 40; k++) begin
      stp = (k == 0) || (k >= 8 && (k - 8) % 4 == 0);
      prev = exp_rate;
      if (stp && exp_rate > 1) exp_rate--;
      cyc();
      chk($sformatf("hold_dn_k%0d_rate", k), int'(o_rate), exp_rate);
      chk($sformatf("hold_dn_k%0d_chg", k), int'(o_rate_chg), int'(prev != exp_rate));
    end
    chg0 = chg_cnt;
    i_key_down = 1'b0;
    repeat (10) cyc();
    chk("release_rate", int'(o_rate), 1);
    chk("release_chg", chg_cnt - chg0, 0);

    // Hold up into REPEAT (edges 0, 8, 12 step), then reset with key held.
    i_key_up = 1'b1;
    repeat (14) cyc();
    chk("hold_up_rate", int'(o_rate), 4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_rate", int'(o_rate), 1);
    chk("midrst_fast", int'(o_fast), 1);
    chk("midrst_chg", int'(o_rate_chg), 0);
    chk("midrst_step_en", int'(o_step_en), 0);
    chk("midrst_step_inc", int'(o_step_inc), 0);
    chg0 = chg_cnt;
    repeat (20) cyc();
    chk("post_rst_held_rate", int'(o_rate), 1);
    chk("post_rst_held_chg", chg_cnt - chg0, 0);
    i_key_up = 1'b0;
    cyc();
    i_key_up = 1'b1;
    cyc();
    i_key_up = 1'b0;
    chk("repress_rate", int'(o_rate), 2);
    chk("repress_chg", int'(o_rate_chg), 1);
    cyc();

    chk("final_sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
